coincidence_counter: RTL and testbench

COINCIDENCE_COUNTER -- requirements
Module: coincidence_counter

---
 rtl/coincidence_counter.sv | 213 +++++++++++++++++++++
 tb/tb_coincidence_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coincidence_counter.sv
// Two-channel PMT singles and coincidence counter with BCD gate latching.
// Define COINC_BLANK_LEADING_ZERO_EN to blank leading zero digits as 4'hF.
module coincidence_counter #(
  parameter int unsigned GATE_CYCLES  = 100_000_000,
  parameter int unsigned COINC_WINDOW = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pmt_a,
  input  logic        pmt_b,
  input  logic        clear,
  output logic [15:0] digits_A,
  output logic [15:0] digits_B,
  output logic [15:0] digits_C,
  output logic [2:0]  overflow,
  output logic        gate_done
);

  localparam logic [31:0] GateTc = 32'(GATE_CYCLES - 1);
  localparam logic [7:0]  Win    = 8'(COINC_WINDOW);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_B,
    WAIT_A
  } state_e;

  logic [2:0]       sa_q, sb_q;
  logic             ea_q, eb_q;
  logic             ev_a, ev_b, coin;
  state_e           state_q, state_d;
  logic [7:0]       win_q, win_d;
  logic [31:0]      gate_q, gate_d;
  logic             tc;
  logic [2:0]       inc;
  logic [2:0][15:0] run_q, run_inc, run_d;
  logic [2:0]       ovf_q, ovf_inc, ovf_d;
  logic [2:0][15:0] dig_q;
  logic [2:0]       ovl_q;
  logic             done_q;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] disp(input logic [15:0] v);
`ifdef COINC_BLANK_LEADING_ZERO_EN
    logic [15:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 3; i > 0; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
`else
    return v;
`endif
  endfunction

  // 2-flop synchroniser, history flop, registered edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q <= '0;
      sb_q <= '0;
      ea_q <= 1'b0;
      eb_q <= 1'b0;
    end else begin
      sa_q <= {sa_q[1:0], pmt_a};
      sb_q <= {sb_q[1:0], pmt_b};
      ea_q <= sa_q[1] & ~sa_q[2];
      eb_q <= sb_q[1] & ~sb_q[2];
    end
  end

  assign ev_a = ea_q & ~clear;
  assign ev_b = eb_q & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (ev_a && !ev_b) begin
          state_d = WAIT_B;
          win_d   = Win;
        end else if (ev_b && !ev_a) begin
          state_d = WAIT_A;
          win_d   = Win;
        end
      end
      WAIT_B: begin
        if (ev_b) begin
          state_d = IDLE;
        end else if (ev_a) begin
          win_d = Win;
        end else begin
          win_d = win_q - 8'd1;
          if (win_q == 8'd1) state_d = IDLE;
        end
      end
      WAIT_A: begin
        if (ev_a) begin
          state_d = IDLE;
        end else if (ev_b) begin
          win_d = Win;
        end else begin
          win_d = win_q - 8'd1;
          if (win_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      win_d   = '0;
    end
  end

  always_comb begin
    coin = 1'b0;
    unique case (state_q)
      IDLE:    coin = ev_a & ev_b;
      WAIT_B:  coin = ev_b;
      WAIT_A:  coin = ev_a;
      default: coin = 1'b0;
    endcase
  end

  assign inc = {coin, ev_b, ev_a};
  assign tc  = (gate_q == GateTc);

  always_comb begin
    run_inc = run_q;
    ovf_inc = ovf_q;
    for (int i = 0; i < 3; i++) begin
      if (inc[i]) begin
        if (run_q[i] == 16'h9999) ovf_inc[i] = 1'b1;
        else run_inc[i] = bcd_inc(run_q[i]);
      end
    end
  end

  always_comb begin
    gate_d = gate_q + 32'd1;
    run_d  = run_inc;
    ovf_d  = ovf_inc;
    if (clear || tc) begin
      gate_d = '0;
      run_d  = '0;
      ovf_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      run_q  <= '0;
      ovf_q  <= '0;
    end else begin
      gate_q <= gate_d;
      run_q  <= run_d;
      ovf_q  <= ovf_d;
    end
  end

  // terminal count latches the counts including this cycle's increments
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q  <= '0;
      ovl_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= tc & ~clear;
      if (tc && !clear) begin
        for (int i = 0; i < 3; i++) dig_q[i] <= disp(run_inc[i]);
        ovl_q <= ovf_inc;
      end
    end
  end

  assign digits_A  = dig_q[0];
  assign digits_B  = dig_q[1];
  assign digits_C  = dig_q[2];
  assign overflow  = ovl_q;
  assign gate_done = done_q;

endmodule

// File: tb/tb_coincidence_counter.sv
// Bench for coincidence_counter: timestamp-based model plus directed cases.
// A second instance with a long gate exercises counter saturation.
module tb_coincidence_counter;

  localparam int G  = 100;
  localparam int W  = 5;
  localparam int GB = 20100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pa = 1'b0, pb = 1'b0, clr = 1'b0;
  logic qa = 1'b0, qb = 1'b0, qclr = 1'b0;
  logic [15:0] dA, dB, dC, bA, bB, bC;
  logic [2:0] ov, bov;
  logic gate_done, bg_done;

  int n_cmp = 0;
  int n_bad = 0;

  coincidence_counter #(.GATE_CYCLES(G), .COINC_WINDOW(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .pmt_a(pa), .pmt_b(pb), .clear(clr),
    .digits_A(dA), .digits_B(dB), .digits_C(dC),
    .overflow(ov), .gate_done(gate_done)
  );

  coincidence_counter #(.GATE_CYCLES(GB), .COINC_WINDOW(W)) u_big (
    .clk(clk), .rst_n(rst_n), .pmt_a(qa), .pmt_b(qb), .clear(qclr),
    .digits_A(bA), .digits_B(bB), .digits_C(bC),
    .overflow(bov), .gate_done(bg_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] disp(input logic [15:0] v);
    logic [15:0] r;
    r = v;
`ifdef COINC_BLANK_LEADING_ZERO_EN
    if (r[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'd0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: edges are timestamps, a pending opener matches within W cycles
  logic ha[5], hb[5];
  int ca, cb, cc, pos, pside, pt, tm;
  logic [2:0] mov;
  logic [15:0] e_a, e_b, e_c;
  logic [2:0] e_ov;
  logic e_done;

  task automatic model_step();
    logic ea, eb, coin;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        ha[i] = 1'b0;
        hb[i] = 1'b0;
      end
      ca = 0; cb = 0; cc = 0; mov = '0;
      pos = 0; pside = 0; pt = 0; tm = 0;
      e_a = '0; e_b = '0; e_c = '0; e_ov = '0; e_done = 1'b0;
    end else begin
      for (int i = 4; i > 0; i--) begin
        ha[i] = ha[i-1];
        hb[i] = hb[i-1];
      end
      ha[0] = pa;
      hb[0] = pb;
      ea = ha[3] & ~ha[4];
      eb = hb[3] & ~hb[4];
      tm++;
      e_done = 1'b0;
      if (clr) begin
        ca = 0; cb = 0; cc = 0; mov = '0; pside = 0; pos = 0;
      end else begin
        coin = 1'b0;
        if (pside == 1 && tm - pt <= W) begin
          if (eb) begin coin = 1'b1; pside = 0; end
          else if (ea) pt = tm;
        end else if (pside == 2 && tm - pt <= W) begin
          if (ea) begin coin = 1'b1; pside = 0; end
          else if (eb) pt = tm;
        end else begin
          pside = 0;
          if (ea && eb) coin = 1'b1;
          else if (ea) begin pside = 1; pt = tm; end
          else if (eb) begin pside = 2; pt = tm; end
        end
        if (ea) begin if (ca == 9999) mov[0] = 1'b1; else ca++; end
        if (eb) begin if (cb == 9999) mov[1] = 1'b1; else cb++; end
        if (coin) begin if (cc == 9999) mov[2] = 1'b1; else cc++; end
        pos++;
        if (pos == G) begin
          e_a = disp(to_bcd(ca));
          e_b = disp(to_bcd(cb));
          e_c = disp(to_bcd(cc));
          e_ov = mov;
          e_done = 1'b1;
          ca = 0; cb = 0; cc = 0; mov = '0; pos = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_A", dA, e_a);
        chk("cyc_B", dB, e_b);
        chk("cyc_C", dC, e_c);
        chk("cyc_ov", {13'd0, ov}, {13'd0, e_ov});
        chk("cyc_done", {15'd0, gate_done}, {15'd0, e_done});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a();
    pa = 1'b1; idle(1); pa = 1'b0; idle(1);
  endtask

  task automatic do_clear();
    clr = 1'b1; idle(1); clr = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int budget, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = big ? bg_done : gate_done;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_timeout: got no gate_done expected one within %0d cycles", nm, budget);
    end
  endtask

  task automatic chk_small(input string nm, input int a, input int b, input int c);
    chk({nm, "_A"}, dA, disp(to_bcd(a)));
    chk({nm, "_B"}, dB, disp(to_bcd(b)));
    chk({nm, "_C"}, dC, disp(to_bcd(c)));
    chk({nm, "_ov"}, {13'd0, ov}, 16'd0);
  endtask

  initial begin
    idle(2);
    chk("rst_A", dA, 16'h0000);
    chk("rst_ov", {13'd0, ov}, 16'd0);
    chk("rst_done", {15'd0, gate_done}, 16'd0);
    rst_n = 1'b1;

    // saturation on the long-gate instance
    repeat (10005) begin
      qa = 1'b1; idle(1); qa = 1'b0; idle(1);
    end
    wait_done(1'b1, 400, "sat");
    chk("sat_A", bA, disp(16'h9999));
    chk("sat_B", bB, disp(16'h0000));
    chk("sat_C", bC, disp(16'h0000));
    chk("sat_ov", {13'd0, bov}, 16'd1);
    wait_done(1'b1, GB + 200, "sat_next");
    chk("sat_next_A", bA, disp(16'h0000));
    chk("sat_next_ov", {13'd0, bov}, 16'd0);

    // singles only
    do_clear();
    repeat (7) pulse_a();
    idle(10);
    repeat (3) begin
      pb = 1'b1; idle(1); pb = 1'b0; idle(1);
    end
    wait_done(1'b0, 150, "singles");
    chk_small("singles", 7, 3, 0);

    // pair 3 apart, pair 7 apart
    do_clear();
    pa = 1'b1; idle(1); pa = 1'b0; idle(2);
    pb = 1'b1; idle(1); pb = 1'b0; idle(20);
    pa = 1'b1; idle(1); pa = 1'b0; idle(6);
    pb = 1'b1; idle(1); pb = 1'b0;
    wait_done(1'b0, 150, "pairs");
    chk_small("pairs", 2, 2, 1);

    // simultaneous edges, then lone b 3 later
    do_clear();
    pa = 1'b1; pb = 1'b1; idle(1); pa = 1'b0; pb = 1'b0; idle(2);
    pb = 1'b1; idle(1); pb = 1'b0;
    wait_done(1'b0, 150, "same");
    chk_small("same", 1, 2, 1);

    // window edge, retrigger, mirror
    do_clear();
    pa = 1'b1; idle(1); pa = 1'b0; idle(4);
    pb = 1'b1; idle(1); pb = 1'b0; idle(15);
    pa = 1'b1; idle(1); pa = 1'b0; idle(5);
    pb = 1'b1; idle(1); pb = 1'b0; idle(15);
    pa = 1'b1; idle(1); pa = 1'b0; idle(3);
    pa = 1'b1; idle(1); pa = 1'b0; idle(3);
    pb = 1'b1; idle(1); pb = 1'b0; idle(15);
    pb = 1'b1; idle(1); pb = 1'b0; idle(1);
    pa = 1'b1; idle(1); pa = 1'b0;
    wait_done(1'b0, 150, "window");
    chk_small("window", 5, 4, 3);

    // clear discards prior counts and its own-cycle event
    do_clear();
    repeat (3) pulse_a();
    pa = 1'b1; idle(1); pa = 1'b0; idle(2);
    clr = 1'b1; idle(1); clr = 1'b0; idle(5);
    pulse_a();
    wait_done(1'b0, 150, "clear");
    chk_small("clear", 1, 0, 0);

    // a edge on terminal count, b edge on first cycle of next gate
    do_clear();
    idle(96);
    pa = 1'b1; idle(1); pa = 1'b0;
    pb = 1'b1; idle(1); pb = 1'b0;
    wait_done(1'b0, 20, "bound1");
    chk_small("bound1", 1, 0, 0);
    wait_done(1'b0, 150, "bound2");
    chk_small("bound2", 0, 1, 1);

    // asynchronous reset mid-gate
    pulse_a();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_A", dA, 16'h0000);
    chk("arst_B", dB, 16'h0000);
    chk("arst_C", dC, 16'h0000);
    chk("arst_ov", {13'd0, ov}, 16'd0);
    chk("arst_done", {15'd0, gate_done}, 16'd0);
    chk("arst_bigA", bA, 16'h0000);
    chk("arst_bigov", {13'd0, bov}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_done(1'b0, 150, "empty");
    chk_small("empty", 0, 0, 0);

    do_clear();
    repeat (42) pulse_a();
    wait_done(1'b0, 150, "n42");
    chk("n42_A", dA, disp(16'h0042));
    chk_small("n42", 42, 0, 0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
